// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel word to serial bit stream feeder with one-word holding buffer
// Optional even-parity bit per word when SERIAL_PARITY_EN is defined.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  buf_word;
    logic              buf_full;
    logic              ready_en;
    logic [WIDTH-1:0]  sh_reg;
    logic [CW-1:0]     bit_cnt;
    logic [3:0]        gap_cnt;
    logic              accept;
    logic              load_shift;
    logic              shift_step;
    logic              gap_start;
    logic              idle_decide;
    logic              word_end;
`ifdef SERIAL_PARITY_EN
    logic              par_bit;
`endif

    // ready_en keeps din_ready low until the first edge after reset release
    assign din_ready = ready_en & ~buf_full;
    assign accept    = din_valid & din_ready;
    assign busy      = (state != ST_IDLE) | buf_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_shift  = 1'b0;
        shift_step  = 1'b0;
        gap_start   = 1'b0;
        idle_decide = 1'b0;
        word_end    = 1'b0;
        x           = 1'b0;
        x_valid     = 1'b0;
        word_done   = 1'b0;
        case (state)
            ST_IDLE: idle_decide = 1'b1;
            ST_SHIFT: begin
                x          = (MSB_FIRST != 0) ? sh_reg[WIDTH-1] : sh_reg[0];
                x_valid    = 1'b1;
                shift_step = 1'b1;
                if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    word_end  = 1'b1;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            ST_PAR: begin
                x        = par_bit;
                x_valid  = 1'b1;
                word_end = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    idle_decide = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (word_end) begin
            word_done = 1'b1;
            if (GAP > 0) begin
                state_nxt = ST_GAP;
                gap_start = 1'b1;
            end else begin
                idle_decide = 1'b1;
            end
        end

        // a waiting word is reloaded on the deciding edge, so back-to-back words have no bubble
        if (idle_decide) begin
            if (buf_full) begin
                load_shift = 1'b1;
                state_nxt  = ST_SHIFT;
            end else begin
                state_nxt  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            buf_word <= '0;
            buf_full <= 1'b0;
            sh_reg   <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= 4'd0;
        end else begin
            ready_en <= 1'b1;

            if (accept) begin
                buf_word <= din;
                buf_full <= 1'b1;
            end else if (load_shift) begin
                buf_full <= 1'b0;
            end

            if (load_shift) begin
                sh_reg  <= buf_word;
                bit_cnt <= '0;
            end else if (shift_step) begin
                sh_reg  <= (MSB_FIRST != 0) ? {sh_reg[WIDTH-2:0], 1'b0}
                                            : {1'b0, sh_reg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (gap_start) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (load_shift) begin
            par_bit <= ^buf_word;
        end
    end
`endif

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - randomized self-checking bench for serial_bit_feeder (two configurations)
module tb_serial_bit_feeder;

    localparam int W  = 8;
    localparam int M0 = 1;
    localparam int G0 = 0;
    localparam int M1 = 0;
    localparam int G1 = 3;
`ifdef SERIAL_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din [2];
    logic         dv  [2];
    logic         rdy [2];
    logic         x   [2];
    logic         xv  [2];
    logic         wd  [2];
    logic         bsy [2];

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(M0), .GAP(G0)) dut0 (
        .clk(clk), .reset(reset), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
        .x(x[0]), .x_valid(xv[0]), .word_done(wd[0]), .busy(bsy[0]));

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(M1), .GAP(G1)) dut1 (
        .clk(clk), .reset(reset), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
        .x(x[1]), .x_valid(xv[1]), .word_done(wd[1]), .busy(bsy[1]));

    // Model: each accepted word gets a start cycle; its bits occupy start..start+L-1
    logic [W-1:0] wdat [2][4];
    int           ws   [2][4];
    int           wptr [2];
    int           last_end [2];
    bit           rdy_en_m;
    bit           in_rst;
    bit           acc_last [2];
    int           n;
    int           total;
    int           passed;

    int           lg_n  [2][64];
    logic         lg_x  [2][64];
    logic         lg_wd [2][64];
    int           lg_cnt [2];

    function automatic int gapof(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    function automatic int msbf(input int i);
        return (i == 0) ? M0 : M1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit m_ready(input int i);
        bit r;
        r = rdy_en_m && !in_rst;
        for (int k = 0; k < 4; k++) if (ws[i][k] > n) r = 1'b0;
        return r;
    endfunction

    function automatic logic [4:0] m_out(input int i);
        logic xb, xvb, wdb, bb;
        int s, e, idx;
        if (in_rst) return 5'b0;
        xb = 1'b0; xvb = 1'b0; wdb = 1'b0; bb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = ws[i][k];
            e = s + L - 1;
            if (s > n) begin
                bb = 1'b1;
            end else if (n <= e) begin
                xvb = 1'b1;
                bb  = 1'b1;
                idx = n - s;
                if (idx < W) xb = (msbf(i) != 0) ? wdat[i][k][W-1-idx] : wdat[i][k][idx];
                else         xb = ^wdat[i][k];
                wdb = (n == e);
            end else if (n <= e + gapof(i)) begin
                bb = 1'b1;
            end
        end
        return {xb, xvb, wdb, bb, m_ready(i)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) ws[i][k] = -1000;
            wptr[i] = 0;
            last_end[i] = -1000;
        end
        rdy_en_m = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    endtask

    task automatic compare_all();
        logic [4:0] e, a;
        for (int i = 0; i < 2; i++) begin
            e = m_out(i);
            a = {x[i], xv[i], wd[i], bsy[i], rdy[i]};
            total++;
            if (a === e) passed++;
            else $display("FAIL cycle_cmp inst%0d cycle %0d: got x/xv/wd/busy/rdy=%b expected %b", i, n, a, e);
            if (xv[i] === 1'b1 && lg_cnt[i] < 64) begin
                lg_n[i][lg_cnt[i]]  = n;
                lg_x[i][lg_cnt[i]]  = x[i];
                lg_wd[i][lg_cnt[i]] = wd[i];
                lg_cnt[i]++;
            end
        end
    endtask

    task automatic step();
        bit           acc [2];
        logic [W-1:0] dsv [2];
        for (int i = 0; i < 2; i++) begin
            acc[i] = (dv[i] === 1'b1) && m_ready(i);
            dsv[i] = din[i];
        end
        @(posedge clk);
        n++;
        for (int i = 0; i < 2; i++) acc_last[i] = 1'b0;
        if (!in_rst) begin
            rdy_en_m = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    int s;
                    s = imax(n + 1, last_end[i] + gapof(i) + 1);
                    wdat[i][wptr[i]] = dsv[i];
                    ws[i][wptr[i]]   = s;
                    wptr[i]          = (wptr[i] + 1) % 4;
                    last_end[i]      = s + L - 1;
                    acc_last[i]      = 1'b1;
                end
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_assert();
        reset  = 1'b0;
        in_rst = 1'b1;
        model_clear();
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int cnt);
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        repeat (cnt) step();
        lg_cnt[0] = 0;
        lg_cnt[1] = 0;
    endtask

    // Feeds two words per instance, advancing on each modelled acceptance
    task automatic send_pair(input logic [W-1:0] a0, input logic [W-1:0] b0,
                             input logic [W-1:0] a1, input logic [W-1:0] b1,
                             input bit en0, input bit en1, input int cycles);
        int idx [2];
        idx[0] = 0; idx[1] = 0;
        din[0] = a0; din[1] = a1;
        dv[0] = en0; dv[1] = en1;
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc_last[i]) begin
                    idx[i]++;
                    if (idx[i] == 1) din[i] = (i == 0) ? b0 : b1;
                    else dv[i] = 1'b0;
                end
            end
            if (c == 0) check("ready_low_while_full", int'(rdy[0]), en0 ? 0 : 1);
        end
        dv[0] = 1'b0; dv[1] = 1'b0;
    endtask

    initial begin
        int d;
        logic [15:0] v;
        total = 0; passed = 0; n = 0;
        in_rst = 1'b1;
        reset  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0; dv[i] = 1'b0; lg_cnt[i] = 0; acc_last[i] = 1'b0;
        end
        model_clear();

        repeat (3) step();
        check("reset_ready", int'(rdy[0]), 0);
        check("reset_busy", int'(bsy[0]), 0);
        reset = 1'b1;
        in_rst = 1'b0;
        #1;
        check("ready_before_first_edge", int'(rdy[1]), 0);
        step();
        check("ready_after_release", int'(rdy[0]), 1);

        // Single word 8'hB4 into both configurations
        lg_cnt[0] = 0; lg_cnt[1] = 0;
        d = n;
        din[0] = 8'hB4; din[1] = 8'hB4; dv[0] = 1'b1; dv[1] = 1'b1;
        step();
        dv[0] = 1'b0; dv[1] = 1'b0;
        repeat (20) step();
        check("b4_bit_count_msb", lg_cnt[0], L);
        check("b4_bit_count_lsb", lg_cnt[1], L);
        v = '0;
        for (int j = 0; j < W; j++) v = {v[14:0], lg_x[0][j]};
        check("b4_msb_first_bits", int'(v), 16'h00B4);
        v = '0;
        for (int j = 0; j < W; j++) v = {v[14:0], lg_x[1][j]};
        check("b4_lsb_first_bits", int'(v), 16'h002D);
        check("b4_first_bit_latency", lg_n[0][0] - d, 2);
        check("b4_word_done_cycle", lg_n[0][L-1] - d, L + 1);
        check("b4_word_done_flag", int'(lg_wd[0][L-1]), 1);
`ifdef SERIAL_PARITY_EN
        check("b4_parity_bit", int'(lg_x[0][W]), 0);
`endif

        // Back-to-back: FF/00 with no gap on inst0, 81/42 with GAP=3 on inst1
        idle_steps(5);
        send_pair(8'hFF, 8'h00, 8'h81, 8'h42, 1'b1, 1'b1, 50);
        check("b2b_bit_count", lg_cnt[0], 2 * L);
        check("b2b_contiguous", lg_n[0][2*L-1] - lg_n[0][0], 2 * L - 1);
`ifndef SERIAL_PARITY_EN
        v = '0;
        for (int j = 0; j < 16; j++) v = {v[14:0], lg_x[0][j]};
        check("b2b_ff00_bits", int'(v), 16'hFF00);
`endif
        check("gap_word_done", int'(lg_wd[1][L-1]), 1);
        check("gap_idle_cycles", lg_n[1][L] - lg_n[1][L-1] - 1, 3);

`ifdef SERIAL_PARITY_EN
        idle_steps(5);
        send_pair(8'h07, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0, 40);
        check("par07_bit", int'(lg_x[0][8]), 1);
        check("par07_done_on_9th", int'(lg_wd[0][8]), 1);
        check("par07_no_done_on_8th", int'(lg_wd[0][7]), 0);
        check("par03_bit", int'(lg_x[0][17]), 0);
`endif

        // Randomized traffic with occasional resets; din changes freely while not ready
        idle_steps(5);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                din[i] = W'($urandom);
                dv[i]  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 399) == 0) begin
                reset_assert();
                step();
                step();
                reset  = 1'b1;
                in_rst = 1'b0;
            end
            step();
            if (lg_cnt[0] > 60) lg_cnt[0] = 0;
            if (lg_cnt[1] > 60) lg_cnt[1] = 0;
        end

        // Reset during bit 4 of 8'hA5 with 8'h3C buffered
        idle_steps(30);
        din[0] = 8'hA5; dv[0] = 1'b1;
        for (int k = 0; k < 20 && lg_cnt[0] < 5; k++) begin
            step();
            if (acc_last[0]) begin
                if (din[0] == 8'hA5) din[0] = 8'h3C;
                else dv[0] = 1'b0;
            end
        end
        check("bit4_reached", int'(lg_cnt[0] >= 5), 1);
        check("buffer_holds_second", int'(bsy[0] && !rdy[0]), 1);
        dv[0] = 1'b0;
        reset_assert();
        check("rst_mid_x", int'(x[0]), 0);
        check("rst_mid_xv", int'(xv[0]), 0);
        check("rst_mid_busy", int'(bsy[0]), 0);
        step();
        reset  = 1'b1;
        in_rst = 1'b0;
        lg_cnt[0] = 0;
        repeat (30) step();
        check("no_bits_after_reset", lg_cnt[0], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per word (legal 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning bit order (1 = din[WIDTH-1] first, 0 = din[0] first).
REQ-003 The block SHALL have parameter GAP, default 0, meaning idle cycles inserted after each word (legal 0..15).
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 Port din  input  WIDTH  parallel word to serialize.
REQ-007 Port din_valid  input  1  din holds a word to transfer.
REQ-008 Port din_ready  output  1  block can accept a word this cycle.
REQ-009 Port x  output  1  serial bit stream to the downstream sequence detector.
REQ-010 Port x_valid  output  1  x carries a word bit this cycle.
REQ-011 Port word_done  output  1  one-cycle pulse on the final serial bit of a word.
REQ-012 Port busy  output  1  shift register or holding buffer occupied.

Function
REQ-013 Transfer SHALL occur on a rising clk edge where din_valid=1 and din_ready=1; din is captured into a one-word holding buffer.
REQ-014 din_ready SHALL equal NOT buffer_full, combinational from registered state only (never from din_valid).
REQ-015 FSM states SHALL be IDLE, SHIFT, PAR (only with parity feature), GAP.
REQ-016 IDLE: if buffer full, move buffer to shift register, clear buffer, enter SHIFT on the same edge.
REQ-017 SHIFT: x SHALL present one bit per cycle for WIDTH cycles in MSB_FIRST order; a bit counter 0..WIDTH-1 tracks position.
REQ-018 First bit of a word SHALL appear on x the cycle after the buffer-to-shift-register move (latency from accept to first bit: 2 cycles when IDLE, buffer empty).
REQ-019 After the last data bit: to PAR if parity enabled, else to GAP if GAP>0, else to SHIFT (buffer full, reload same edge, no bubble) or IDLE.
REQ-020 GAP: hold x=0, x_valid=0 for exactly GAP cycles, then behave as IDLE decision.
REQ-021 Outside SHIFT/PAR, x SHALL be 0 and x_valid 0, so the detector sees a steady 0.
REQ-022 Buffer load and buffer-to-shift move on the same edge SHALL both succeed (buffer stays full with the new word).
REQ-023 din changes while din_ready=0 SHALL be ignored; a held word is never overwritten.
REQ-024 word_done SHALL assert with the last bit (data bit WIDTH-1, or parity bit when enabled).
REQ-025 busy SHALL be 1 whenever FSM is not IDLE or buffer is full.

Reset
REQ-026 reset=0 SHALL immediately force: FSM=IDLE, buffer empty, counter 0, x=0, x_valid=0, word_done=0, busy=0, din_ready=0.
REQ-027 reset asserted mid-word SHALL discard the shifting and buffered words; no partial bits after release.
REQ-028 din_ready SHALL go 1 on the first clk edge after reset deasserts.

Configuration
REQ-029 Macro SERIAL_PARITY_EN defined: after the last data bit, state PAR emits one even-parity bit (XOR of the word's data bits), x_valid=1.
REQ-030 SERIAL_PARITY_EN undefined: PAR state and parity logic absent; each word is exactly WIDTH serial bits.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1: accept 8'hB4 while idle -> x = 1,0,1,1,0,1,0,0 on cycles 2..9 after accept, word_done on cycle 9.
REQ-032 MSB_FIRST=0: accept 8'hB4 -> x = 0,0,1,0,1,1,0,1, x_valid high exactly 8 cycles.
REQ-033 GAP=0, din_valid held with 8'hFF then 8'h00 -> 16 contiguous x_valid cycles, eight 1s then eight 0s, din_ready low while buffer full.
REQ-034 GAP=3: two back-to-back words -> exactly 3 cycles x_valid=0, x=0 between word_done and next first bit.
REQ-035 SERIAL_PARITY_EN, word 8'h07 -> 8 data bits then parity bit 1, word_done on the 9th bit; word 8'h03 -> parity bit 0.
REQ-036 reset pulsed low at bit 4 of 8'hA5 with buffer holding 8'h3C -> x=0, x_valid=0, busy=0 during reset; no bits of either word after release.
